// File: rtl/regfile_mp_pkg.sv
// Shared register-file constants and control state encoding.
package regfile_mp_pkg;
    localparam int WORD_LEN          = 32;
    localparam int REG_FILE_ADDR_LEN = 5;
    localparam int REG_FILE_SIZE     = 32;

    typedef enum logic {
        RF_INIT = 1'b0,
        RF_RUN  = 1'b1
    } rf_state_e;
endpackage

// File: rtl/regfile_mp_wr_arb.sv
// Winner select for one queried address across all write ports.
// The highest-index matching port wins; coll flags two or more matches.
module regfile_wr_arb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_WR = 2
) (
    input  logic [NUM_WR-1:0]             en,
    input  logic [NUM_WR-1:0][ADDR_W-1:0] addr,
    input  logic [NUM_WR-1:0][DATA_W-1:0] data,
    input  logic [ADDR_W-1:0]             q,
    output logic [DATA_W-1:0]             win_data,
    output logic                          hit,
    output logic                          coll
);
    always_comb begin
        win_data = '0;
        hit      = 1'b0;
        coll     = 1'b0;
        for (int j = 0; j < NUM_WR; j++) begin
            if (en[j] && addr[j] == q) begin
                coll     = coll | hit;
                hit      = 1'b1;
                win_data = data[j];
            end
        end
    end
endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write-first bypass, optional zero register
// and a post-reset clear sweep that walks one entry per cycle.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W   = WORD_LEN,
    parameter int ADDR_W   = REG_FILE_ADDR_LEN,
    parameter int DEPTH    = REG_FILE_SIZE,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    output logic                     init_busy,
    output logic                     wr_collision
);
    localparam int CLR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

    rf_state_e                       state;
    logic [CLR_W-1:0]                clr_ptr;
    logic [DATA_W-1:0]               mem [DEPTH];
    logic                            run;
    logic [NUM_WR-1:0][ADDR_W-1:0]   wa;
    logic [NUM_WR-1:0][DATA_W-1:0]   wd;
    logic [NUM_WR-1:0]               wv;
    logic [DEPTH-1:0][DATA_W-1:0]    st_data;
    logic [DEPTH-1:0]                st_hit;
    logic [DEPTH-1:0]                st_coll;
    logic [NUM_RD-1:0]               rd_coll;

    // Addresses that hold real storage: in range and not the hardwired zero.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH_X) && !(ZERO_REG != 0 && a == '0);
    endfunction

    assign run       = (state == RF_RUN) && !rst;
    assign init_busy = !run;

    for (genvar j = 0; j < NUM_WR; j++) begin : g_wr
        assign wa[j] = wr_addr[j*ADDR_W +: ADDR_W];
        assign wd[j] = wr_data[j*DATA_W +: DATA_W];
        assign wv[j] = run && wr_en[j] && addr_ok(wa[j]);
    end

    for (genvar a = 0; a < DEPTH; a++) begin : g_st
        regfile_wr_arb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_WR(NUM_WR)) u_arb (
            .en(wv), .addr(wa), .data(wd), .q(ADDR_W'(a)),
            .win_data(st_data[a]), .hit(st_hit[a]), .coll(st_coll[a])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int a = 0; a < DEPTH; a++) begin
                if (state == RF_INIT && clr_ptr == CLR_W'(a))
                    mem[a] <= '0;
                else if (st_hit[a])
                    mem[a] <= st_data[a];
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] byp_data;
        logic              byp_hit;

        assign ra = rd_addr[i*ADDR_W +: ADDR_W];

        regfile_wr_arb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_WR(NUM_WR)) u_byp (
            .en(wv), .addr(wa), .data(wd), .q(ra),
            .win_data(byp_data), .hit(byp_hit), .coll(rd_coll[i])
        );

        assign rd_data[i*DATA_W +: DATA_W] =
            (run && addr_ok(ra)) ? (byp_hit ? byp_data : mem[ra]) : '0;
    end

    // Read-side collision flags only ever repeat what the storage arbiters see.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RF_INIT;
            clr_ptr      <= '0;
            wr_collision <= 1'b0;
        end else begin
            case (state)
                RF_INIT: begin
                    clr_ptr      <= clr_ptr + 1'b1;
                    wr_collision <= 1'b0;
                    if (clr_ptr == CLR_W'(DEPTH - 1))
                        state <= RF_RUN;
                end
                default: wr_collision <= |st_coll | |rd_coll;
            endcase
        end
    end
endmodule
